// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory; one access per two cycles.
// Optional round-robin arbitration is enabled by defining DMEM_ARB_RR_EN (default: fixed priority to port 0).
module dmem_arbiter #(
   parameter int DW = 32,
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_valid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_valid,
   output logic [DW-1:0] m1_rdata,
   output logic [AW-1:0] mem_A,
   output logic [DW-1:0] mem_WD,
   output logic          mem_WE,
   input  logic [DW-1:0] mem_RD
);

   typedef enum logic {IDLE, SERVE} state_t;

   state_t        state, state_nxt;
   logic          take;
   logic          pick;
   logic          win_p1;
   logic          we_p1;
   logic [AW-1:0] addr_p1;
   logic [DW-1:0] wdata_p1;

`ifdef DMEM_ARB_RR_EN
   logic          last_p1;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      pick      = 1'b0;
      mem_A     = '0;
      mem_WD    = '0;
      mem_WE    = 1'b0;
      m0_gnt    = 1'b0;
      m1_gnt    = 1'b0;
      case (state)
         IDLE: begin
            if (m0_req || m1_req) begin
               take      = 1'b1;
               state_nxt = SERVE;
               if (m0_req && m1_req) begin
`ifdef DMEM_ARB_RR_EN
                  pick = ~last_p1;
`else
                  pick = 1'b0;
`endif
               end else begin
                  pick = m1_req;
               end
            end
         end
         SERVE: begin
            // SERVE always lasts exactly one cycle, so the grant pulse is tied to it
            state_nxt = IDLE;
            mem_A     = addr_p1;
            mem_WD    = wdata_p1;
            mem_WE    = we_p1 & ~rst;
            m0_gnt    = ~win_p1;
            m1_gnt    = win_p1;
         end
      endcase
   end

   // ---- p1: command latched at the grant edge, completion captured at the end of SERVE
   always_ff @(posedge clk) begin
      if (rst) begin
         win_p1   <= 1'b0;
         we_p1    <= 1'b0;
         addr_p1  <= '0;
         wdata_p1 <= '0;
         m0_valid <= 1'b0;
         m1_valid <= 1'b0;
         m0_rdata <= '0;
         m1_rdata <= '0;
`ifdef DMEM_ARB_RR_EN
         last_p1  <= 1'b1;
`endif
      end else begin
         m0_valid <= (state == SERVE) & ~win_p1;
         m1_valid <= (state == SERVE) &  win_p1;
         if ((state == SERVE) && !we_p1) begin
            if (win_p1) m1_rdata <= mem_RD;
            else        m0_rdata <= mem_RD;
         end
         if (take) begin
            win_p1   <= pick;
            we_p1    <= pick ? m1_we    : m0_we;
            addr_p1  <= pick ? m1_addr  : m0_addr;
            wdata_p1 <= pick ? m1_wdata : m0_wdata;
`ifdef DMEM_ARB_RR_EN
            last_p1  <= pick;
`endif
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model (memory array, expected rdata, arbitration order).
module tb_dmem_arbiter;
   localparam int DW = 32;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m0_we, m1_req, m1_we;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic          m0_gnt, m0_valid, m1_gnt, m1_valid;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic [AW-1:0] mem_A;
   logic [DW-1:0] mem_WD, mem_RD;
   logic          mem_WE;

   logic [DW-1:0] tb_mem [16];
   logic          mem_load;

   int            n_pass  = 0;
   int            n_total = 0;

   logic [DW-1:0] model_mem [16];
   logic [DW-1:0] exp_rd [2];
`ifdef DMEM_ARB_RR_EN
   logic          model_last;
`endif

   always #5 clk = ~clk;

   dmem_arbiter #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_valid(m0_valid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_valid(m1_valid), .m1_rdata(m1_rdata),
      .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
   );

   function automatic logic [DW-1:0] init_word(int i);
      return 32'hA5A5_0000 + 32'(i);
   endfunction

   // single-port memory: combinational read, write on the rising edge
   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 16; i++) tb_mem[i] <= init_word(i);
      end else if (mem_WE) begin
         tb_mem[mem_A[3:0]] <= mem_WD;
      end
   end
   assign mem_RD = tb_mem[mem_A[3:0]];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      clear_reqs();
      tick();
      tick();
      rst = 1'b0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
`ifdef DMEM_ARB_RR_EN
      model_last = 1'b1;
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mem_load = 1'b1;
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd3; m0_wdata = $urandom;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd4; m1_wdata = $urandom;
      tick();
      tick();
      mem_load = 1'b0;
      n_total++; if ({m1_gnt, m0_gnt} !== 2'b00) $display("FAIL reset_gnt: got %b expected 00", {m1_gnt, m0_gnt}); else n_pass++;
      n_total++; if ({m1_valid, m0_valid} !== 2'b00) $display("FAIL reset_valid: got %b expected 00", {m1_valid, m0_valid}); else n_pass++;
      n_total++; if (m0_rdata !== '0) $display("FAIL reset_m0_rdata: got %h expected 0", m0_rdata); else n_pass++;
      n_total++; if (m1_rdata !== '0) $display("FAIL reset_m1_rdata: got %h expected 0", m1_rdata); else n_pass++;
      n_total++; if ({mem_WE, mem_A, mem_WD} !== '0) $display("FAIL reset_mem_bus: got we=%b a=%h wd=%h expected all 0", mem_WE, mem_A, mem_WD); else n_pass++;
      clear_reqs();
      rst = 1'b0;
      tick();
      n_total++; if ({m1_gnt, m0_gnt, m1_valid, m0_valid} !== 4'b0) $display("FAIL idle_after_reset: got %b expected 0000", {m1_gnt, m0_gnt, m1_valid, m0_valid}); else n_pass++;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
`ifdef DMEM_ARB_RR_EN
      model_last = 1'b1;
`endif
   endtask

   task automatic test_write_read();
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd5; m0_wdata = 32'hDEAD_BEEF;
      tick();
      n_total++; if ({m1_gnt, m0_gnt} !== 2'b01) $display("FAIL wr_gnt: got %b expected 01", {m1_gnt, m0_gnt}); else n_pass++;
      n_total++; if (mem_WE !== 1'b1 || mem_A !== 32'd5 || mem_WD !== 32'hDEAD_BEEF)
         $display("FAIL wr_mem_bus: got we=%b a=%h wd=%h expected 1/5/deadbeef", mem_WE, mem_A, mem_WD); else n_pass++;
      n_total++; if (m0_valid !== 1'b0) $display("FAIL wr_early_valid: got %b expected 0", m0_valid); else n_pass++;
      m0_req = 1'b0; m0_addr = $urandom; m0_wdata = $urandom;
      tick();
      model_mem[5] = 32'hDEAD_BEEF;
      n_total++; if ({m0_valid, m0_gnt, mem_WE} !== 3'b100) $display("FAIL wr_valid: got valid,gnt,we=%b expected 100", {m0_valid, m0_gnt, mem_WE}); else n_pass++;
      n_total++; if (tb_mem[5] !== model_mem[5]) $display("FAIL wr_memory5: got %h expected %h", tb_mem[5], model_mem[5]); else n_pass++;
      n_total++; if (m0_rdata !== exp_rd[0]) $display("FAIL wr_rdata_hold: got %h expected %h", m0_rdata, exp_rd[0]); else n_pass++;
      tick();
      n_total++; if (m0_valid !== 1'b0) $display("FAIL wr_valid_pulse: got %b expected 0", m0_valid); else n_pass++;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd5;
      tick();
      n_total++; if ({m1_gnt, m0_gnt, mem_WE} !== 3'b100) $display("FAIL rd_gnt: got gnt1,gnt0,we=%b expected 100", {m1_gnt, m0_gnt, mem_WE}); else n_pass++;
      m1_req = 1'b0;
      tick();
      exp_rd[1] = model_mem[5];
      n_total++; if (m1_valid !== 1'b1 || m1_rdata !== exp_rd[1]) $display("FAIL rd_data: got valid=%b data=%h expected 1/%h", m1_valid, m1_rdata, exp_rd[1]); else n_pass++;
      n_total++; if (m0_rdata !== exp_rd[0] || mem_WE !== 1'b0) $display("FAIL rd_other_port: got m0_rdata=%h we=%b expected %h/0", m0_rdata, mem_WE, exp_rd[0]); else n_pass++;
      tick();
   endtask

   task automatic test_arbitration();
      int   ng;
      int   last_c;
      logic exp_w;
      apply_reset();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd1;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd2;
      ng = 0;
      last_c = 0;
      for (int c = 0; c < 12 && ng < 3; c++) begin
         tick();
         if (m0_gnt || m1_gnt) begin
`ifdef DMEM_ARB_RR_EN
            exp_w = ~model_last;
            model_last = exp_w;
`else
            exp_w = 1'b0;
`endif
            n_total++; if ({m1_gnt, m0_gnt} !== (exp_w ? 2'b10 : 2'b01)) $display("FAIL arb_order_%0d: got %b expected port %0d", ng, {m1_gnt, m0_gnt}, exp_w); else n_pass++;
            if (ng > 0) begin
               n_total++; if (c - last_c !== 2) $display("FAIL arb_spacing: got %0d cycles expected 2", c - last_c); else n_pass++;
            end
            last_c = c;
            ng++;
         end
      end
      n_total++; if (ng !== 3) $display("FAIL arb_grant_count: got %0d expected 3", ng); else n_pass++;
      clear_reqs();
      tick();
      tick();
   endtask

   task automatic test_reset_in_serve();
      logic seen;
      apply_reset();
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'd7; m1_wdata = 32'h1234_5678;
      tick();
      n_total++; if (m1_gnt !== 1'b1) $display("FAIL rsv_gnt: got %b expected 1", m1_gnt); else n_pass++;
      rst = 1'b1;
      m1_req = 1'b0;
      #1;
      n_total++; if (mem_WE !== 1'b0) $display("FAIL rsv_we_suppressed: got %b expected 0", mem_WE); else n_pass++;
      tick();
      n_total++; if (tb_mem[7] !== model_mem[7]) $display("FAIL rsv_memory7: got %h expected %h", tb_mem[7], model_mem[7]); else n_pass++;
      n_total++; if ({m1_gnt, m0_gnt, m1_valid, m0_valid, mem_WE} !== 5'b0 || mem_A !== '0 || mem_WD !== '0 || m0_rdata !== '0 || m1_rdata !== '0)
         $display("FAIL rsv_outputs: got gnt=%b valid=%b we=%b a=%h wd=%h rd0=%h rd1=%h expected all 0",
                  {m1_gnt, m0_gnt}, {m1_valid, m0_valid}, mem_WE, mem_A, mem_WD, m0_rdata, m1_rdata); else n_pass++;
      rst = 1'b0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
`ifdef DMEM_ARB_RR_EN
      model_last = 1'b1;
`endif
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (m1_valid || m1_gnt) seen = 1'b1;
      end
      n_total++; if (seen !== 1'b0) $display("FAIL rsv_no_late_valid: got activity=%b expected 0", seen); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int ng, nv, last_c;
      logic bad;
      apply_reset();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd0;
      ng = 0; nv = 0; last_c = 0; bad = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if ((m0_gnt && m0_valid) || m1_gnt || m1_valid) bad = 1'b1;
         if (m0_valid) begin
            n_total++; if (m0_rdata !== model_mem[nv]) $display("FAIL b2b_rdata_%0d: got %h expected %h", nv, m0_rdata, model_mem[nv]); else n_pass++;
            nv++;
         end
         if (m0_gnt) begin
            if (ng > 0) begin
               n_total++; if (c - last_c !== 2) $display("FAIL b2b_spacing: got %0d cycles expected 2", c - last_c); else n_pass++;
            end
            last_c = c;
            ng++;
            if (ng < 3) m0_addr = 32'(ng);
            else m0_req = 1'b0;
         end
      end
      n_total++; if (ng !== 3 || nv !== 3) $display("FAIL b2b_counts: got gnt=%0d valid=%0d expected 3/3", ng, nv); else n_pass++;
      n_total++; if (bad !== 1'b0) $display("FAIL b2b_exclusive: got overlap=%b expected 0", bad); else n_pass++;
   endtask

   task automatic test_random();
      logic          p_req [2];
      logic          p_we [2];
      logic [AW-1:0] p_addr [2];
      logic [DW-1:0] p_wd [2];
      logic          busy, srv_we, w;
      int            srv_port;
      logic [AW-1:0] srv_addr;
      logic [DW-1:0] srv_wd;
      logic [1:0]    exp_g, exp_v;
      logic          exp_we;
      logic [AW-1:0] exp_a;
      apply_reset();
      busy = 1'b0; srv_we = 1'b0; srv_port = 0; srv_addr = '0; srv_wd = '0;
      for (int p = 0; p < 2; p++) begin
         p_req[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_wd[p] = '0;
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
         tick();
         exp_g = 2'b00; exp_v = 2'b00; exp_we = 1'b0; exp_a = '0;
         if (busy) begin
            busy = 1'b0;
            exp_v[srv_port] = 1'b1;
            if (srv_we) model_mem[srv_addr[3:0]] = srv_wd;
            else        exp_rd[srv_port] = model_mem[srv_addr[3:0]];
         end else if (p_req[0] || p_req[1]) begin
            if (p_req[0] && p_req[1]) begin
`ifdef DMEM_ARB_RR_EN
               w = ~model_last;
`else
               w = 1'b0;
`endif
            end else begin
               w = p_req[1];
            end
`ifdef DMEM_ARB_RR_EN
            model_last = w;
`endif
            srv_port = w ? 1 : 0;
            srv_we = p_we[srv_port]; srv_addr = p_addr[srv_port]; srv_wd = p_wd[srv_port];
            exp_g[srv_port] = 1'b1;
            exp_we = srv_we;
            exp_a = srv_addr;
            busy = 1'b1;
         end
         n_total++; if ({m1_gnt, m0_gnt} !== exp_g) $display("FAIL rnd_gnt @%0d: got %b expected %b", cyc, {m1_gnt, m0_gnt}, exp_g); else n_pass++;
         n_total++; if ({m1_valid, m0_valid} !== exp_v) $display("FAIL rnd_valid @%0d: got %b expected %b", cyc, {m1_valid, m0_valid}, exp_v); else n_pass++;
         n_total++; if (m0_rdata !== exp_rd[0] || m1_rdata !== exp_rd[1])
            $display("FAIL rnd_rdata @%0d: got %h/%h expected %h/%h", cyc, m0_rdata, m1_rdata, exp_rd[0], exp_rd[1]); else n_pass++;
         n_total++; if (mem_WE !== exp_we || mem_A !== exp_a) $display("FAIL rnd_mem_bus @%0d: got we=%b a=%h expected %b/%h", cyc, mem_WE, mem_A, exp_we, exp_a); else n_pass++;
         for (int p = 0; p < 2; p++) begin
            if (exp_g[p]) begin
               p_req[p] = 1'b0;
            end else if (!p_req[p] && $urandom_range(0, 2) != 0) begin
               p_req[p]  = 1'b1;
               p_we[p]   = 1'($urandom_range(0, 1));
               p_addr[p] = 32'($urandom_range(0, 15));
               p_wd[p]   = $urandom;
            end
         end
         m0_req = p_req[0]; m0_we = p_we[0]; m0_addr = p_addr[0]; m0_wdata = p_wd[0];
         m1_req = p_req[1]; m1_we = p_we[1]; m1_addr = p_addr[1]; m1_wdata = p_wd[1];
      end
      clear_reqs();
      tick();
      tick();
   endtask

   initial begin
      rst = 1'b1;
      mem_load = 1'b1;
      clear_reqs();
      for (int i = 0; i < 16; i++) model_mem[i] = init_word(i);
      exp_rd[0] = '0;
      exp_rd[1] = '0;
`ifdef DMEM_ARB_RR_EN
      model_last = 1'b1;
`endif
      test_reset();
      test_write_read();
      test_arbitration();
      test_reset_in_serve();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter: DW, 32, data width of requester and memory data buses.
REQ-002 SHALL have parameter: AW, 32, address width of requester and memory address buses.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: m0_req/m1_req  input  1  access request from requester 0/1.
REQ-006 SHALL have ports: m0_we/m1_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports: m0_addr/m1_addr  input  AW  word address.
REQ-008 SHALL have ports: m0_wdata/m1_wdata  input  DW  write data.
REQ-009 SHALL have ports: m0_gnt/m1_gnt  output  1  one-cycle grant pulse.
REQ-010 SHALL have ports: m0_valid/m1_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports: m0_rdata/m1_rdata  output  DW  registered read data.
REQ-012 SHALL have ports: mem_A  output  AW, mem_WD  output  DW, mem_WE  output  1, mem_RD  input  DW, all connecting to the single-port data memory (combinational read, write on posedge clk when WE).

Function
REQ-013 SHALL implement a two-state FSM: IDLE and SERVE.
REQ-014 In IDLE with any reqX high at a rising edge, SHALL select one winner, latch its we/addr/wdata into internal registers, and enter SERVE.
REQ-015 SHALL assert the winner's gnt for exactly the first cycle of SERVE; the requester then drops req and may change its command inputs.
REQ-016 In SERVE, SHALL drive mem_A = latched addr, mem_WD = latched wdata, mem_WE = latched we AND NOT rst.
REQ-017 In IDLE, SHALL drive mem_A = 0, mem_WD = 0, mem_WE = 0.
REQ-018 At the edge ending SERVE, SHALL capture mem_RD into the winner's rdata (reads only), pulse the winner's valid for one cycle, and return to IDLE.
REQ-019 Latency: req sampled at edge E, gnt high cycle E..E+1, memory access at edge E+1, valid high cycle E+1..E+2; throughput one access per 2 cycles.
REQ-020 The loser of a simultaneous request SHALL keep req asserted and SHALL be served in the next IDLE cycle, with no request lost.
REQ-021 The rdata of the non-winning port and the rdata after a write SHALL hold their previous value.
REQ-022 SHALL never assert both gnt, both valid, or gnt and valid on the same port in the same cycle.
REQ-023 req asserted during SERVE SHALL be ignored until IDLE.

Reset
REQ-024 With rst high at a rising edge, SHALL enter IDLE; m0_gnt, m1_gnt, m0_valid, m1_valid SHALL be 0; m0_rdata, m1_rdata and latched registers SHALL be 0; last-grant SHALL be 1.
REQ-025 rst asserted during SERVE SHALL suppress mem_WE in that cycle (no memory write) and produce no valid pulse.

Configuration
REQ-026 With DMEM_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: the port not granted last wins; last-grant updates on every grant.
REQ-027 Without DMEM_ARB_RR_EN, port 0 SHALL always win simultaneous requests; the last-grant register SHALL be absent.

Verification
REQ-028 Reset then m0 write addr 5, data 0xDEADBEEF -> m0_gnt next cycle, mem_WE=1 with mem_A=5 for one cycle, m0_valid one cycle later, memory[5]=0xDEADBEEF.
REQ-029 m1 read addr 5 after REQ-028 -> m1_valid with m1_rdata=0xDEADBEEF, mem_WE stays 0, m0_rdata unchanged.
REQ-030 m0_req and m1_req high together from reset, RR enabled -> grants m0, m1, m0 in order on consecutive IDLE cycles; RR disabled with both held -> m0 every time, m1 starved.
REQ-031 rst pulsed during SERVE of an m1 write addr 7 data 0x12345678 -> memory[7] unchanged, m1_valid never asserted, FSM in IDLE, all outputs 0.
REQ-032 Back-to-back m0 reads addr 0,1,2 held continuously -> gnt every 2 cycles, three valids with memory[0..2] data, no double grant.
